// File: rtl/coeff_token_if.sv
// Token-in / bit-out handshake bundle of the CAVLC coeff_token writer.
// The producer/consumer side is master; the encoder is slave.
interface coeff_token_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] total_coeff;
    logic [1:0] trailing_ones;
    logic       bit_data;
    logic       bit_valid;
    logic       bit_ready;
    logic       last_bit;
    logic [4:0] code_len;
    logic       error;

    modport master (
        output in_valid, total_coeff, trailing_ones, bit_ready,
        input  in_ready, bit_data, bit_valid, last_bit, code_len, error
    );

    modport slave (
        input  in_valid, total_coeff, trailing_ones, bit_ready,
        output in_ready, bit_data, bit_valid, last_bit, code_len, error
    );
endinterface

// File: rtl/coeff_token_writer02.sv
// Serial CAVLC coeff_token encoder for the 0 <= nC < 2 table: one
// (TotalCoeff, TrailingOnes) token in, its codeword out MSB-first.
module coeff_token_writer02 (
    input  logic        clk,
    input  logic        reset,
    coeff_token_if.slave tok
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_nxt;
    logic [15:0] sh_reg;
    logic [4:0]  remaining;
    logic [4:0]  code_len_q;
    logic        error_q;
    logic        last;
    logic        accept;
    logic        legal;
    logic        load;
    logic        shift;
    logic [20:0] lut;

    // Returns {len, code} with the code left-aligned in 16 bits.
    function automatic logic [20:0] code_lut(input logic [4:0] tc, input logic [1:0] t1);
        logic [4:0]  len;
        logic [15:0] val;
        {len, val} = '0;
        case ({tc, t1})
            {5'd0,  2'd0}: {len, val} = {5'd1,  16'd1};
            {5'd1,  2'd0}: {len, val} = {5'd6,  16'd5};
            {5'd1,  2'd1}: {len, val} = {5'd2,  16'd1};
            {5'd2,  2'd0}: {len, val} = {5'd8,  16'd7};
            {5'd2,  2'd1}: {len, val} = {5'd6,  16'd4};
            {5'd2,  2'd2}: {len, val} = {5'd3,  16'd1};
            {5'd3,  2'd0}: {len, val} = {5'd9,  16'd7};
            {5'd3,  2'd1}: {len, val} = {5'd8,  16'd6};
            {5'd3,  2'd2}: {len, val} = {5'd7,  16'd5};
            {5'd3,  2'd3}: {len, val} = {5'd5,  16'd3};
            {5'd4,  2'd0}: {len, val} = {5'd10, 16'd7};
            {5'd4,  2'd1}: {len, val} = {5'd9,  16'd6};
            {5'd4,  2'd2}: {len, val} = {5'd8,  16'd5};
            {5'd4,  2'd3}: {len, val} = {5'd6,  16'd3};
            {5'd5,  2'd0}: {len, val} = {5'd11, 16'd7};
            {5'd5,  2'd1}: {len, val} = {5'd10, 16'd6};
            {5'd5,  2'd2}: {len, val} = {5'd9,  16'd5};
            {5'd5,  2'd3}: {len, val} = {5'd7,  16'd4};
            {5'd6,  2'd0}: {len, val} = {5'd13, 16'd15};
            {5'd6,  2'd1}: {len, val} = {5'd11, 16'd6};
            {5'd6,  2'd2}: {len, val} = {5'd10, 16'd5};
            {5'd6,  2'd3}: {len, val} = {5'd8,  16'd4};
            {5'd7,  2'd0}: {len, val} = {5'd13, 16'd11};
            {5'd7,  2'd1}: {len, val} = {5'd13, 16'd14};
            {5'd7,  2'd2}: {len, val} = {5'd11, 16'd5};
            {5'd7,  2'd3}: {len, val} = {5'd9,  16'd4};
            {5'd8,  2'd0}: {len, val} = {5'd13, 16'd8};
            {5'd8,  2'd1}: {len, val} = {5'd13, 16'd10};
            {5'd8,  2'd2}: {len, val} = {5'd13, 16'd13};
            {5'd8,  2'd3}: {len, val} = {5'd10, 16'd4};
            {5'd9,  2'd0}: {len, val} = {5'd14, 16'd15};
            {5'd9,  2'd1}: {len, val} = {5'd14, 16'd14};
            {5'd9,  2'd2}: {len, val} = {5'd13, 16'd9};
            {5'd9,  2'd3}: {len, val} = {5'd11, 16'd4};
            {5'd10, 2'd0}: {len, val} = {5'd14, 16'd11};
            {5'd10, 2'd1}: {len, val} = {5'd14, 16'd10};
            {5'd10, 2'd2}: {len, val} = {5'd14, 16'd13};
            {5'd10, 2'd3}: {len, val} = {5'd13, 16'd12};
            {5'd11, 2'd0}: {len, val} = {5'd15, 16'd15};
            {5'd11, 2'd1}: {len, val} = {5'd15, 16'd14};
            {5'd11, 2'd2}: {len, val} = {5'd14, 16'd9};
            {5'd11, 2'd3}: {len, val} = {5'd14, 16'd12};
            {5'd12, 2'd0}: {len, val} = {5'd15, 16'd11};
            {5'd12, 2'd1}: {len, val} = {5'd15, 16'd10};
            {5'd12, 2'd2}: {len, val} = {5'd15, 16'd13};
            {5'd12, 2'd3}: {len, val} = {5'd14, 16'd8};
            {5'd13, 2'd0}: {len, val} = {5'd16, 16'd15};
            {5'd13, 2'd1}: {len, val} = {5'd15, 16'd1};
            {5'd13, 2'd2}: {len, val} = {5'd15, 16'd9};
            {5'd13, 2'd3}: {len, val} = {5'd15, 16'd12};
            {5'd14, 2'd0}: {len, val} = {5'd16, 16'd11};
            {5'd14, 2'd1}: {len, val} = {5'd16, 16'd14};
            {5'd14, 2'd2}: {len, val} = {5'd16, 16'd13};
            {5'd14, 2'd3}: {len, val} = {5'd15, 16'd8};
            {5'd15, 2'd0}: {len, val} = {5'd16, 16'd7};
            {5'd15, 2'd1}: {len, val} = {5'd16, 16'd10};
            {5'd15, 2'd2}: {len, val} = {5'd16, 16'd9};
            {5'd15, 2'd3}: {len, val} = {5'd16, 16'd12};
            {5'd16, 2'd0}: {len, val} = {5'd16, 16'd4};
            {5'd16, 2'd1}: {len, val} = {5'd16, 16'd6};
            {5'd16, 2'd2}: {len, val} = {5'd16, 16'd5};
            {5'd16, 2'd3}: {len, val} = {5'd16, 16'd8};
            default:       {len, val} = '0;
        endcase
        return {len, val << (5'd16 - len)};
    endfunction

    assign lut    = code_lut(tok.total_coeff, tok.trailing_ones);
    assign legal  = (tok.total_coeff <= 5'd16) && ({3'b000, tok.trailing_ones} <= tok.total_coeff);
    assign last   = (state == SHIFT) && (remaining == 5'd1);
    // A new token may enter in the cycle the final bit leaves: zero-bubble streaming.
    assign tok.in_ready = ~reset & ((state == IDLE) | (last & tok.bit_ready));
    assign accept       = tok.in_valid & tok.in_ready;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (tok.bit_ready) begin
                    shift = 1'b1;
                    if (last) begin
                        if (accept && legal) load = 1'b1;
                        else                 state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sh_reg     <= '0;
            remaining  <= '0;
            code_len_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            error_q <= accept & ~legal;
            if (load) begin
                sh_reg     <= lut[15:0];
                remaining  <= lut[20:16];
                code_len_q <= lut[20:16];
            end else if (shift) begin
                sh_reg    <= {sh_reg[14:0], 1'b0};
                remaining <= remaining - 5'd1;
            end
        end
    end

    assign tok.bit_data  = sh_reg[15];
    assign tok.bit_valid = (state == SHIFT);
    assign tok.last_bit  = last;
    assign tok.code_len  = code_len_q;
    assign tok.error     = error_q;
endmodule

// File: doc/coeff_token_writer02.md
# coeff_token_writer02

Serial CAVLC coeff_token encoder for the 0 <= nC < 2 VLC table; it is the encoder-side counterpart of the CoeffTokenROM02 decode path. It accepts one (TotalCoeff, TrailingOnes) pair per handshake, looks up the table codeword of 1–16 bits, and shifts it out MSB-first on a ready/valid bit stream. Illegal pairs are rejected with an Error pulse. The block sits between the residual-block token builder and the CAVLC bitstream packer.

## Interface
- No parameters. Table fixed to 0 <= nC < 2; max code length 16.
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high.
- InValid  input  1  token present on TotalCoeff/TrailingOnes.
- InReady  output  1  block can accept a token this cycle.
- TotalCoeff  input  5  number of nonzero coefficients, legal 0..16.
- TrailingOnes  input  2  trailing ±1 count, legal 0..min(3, TotalCoeff).
- Bit  output  1  current code bit, MSB of codeword first.
- BitValid  output  1  Bit is valid.
- BitReady  input  1  downstream consumes Bit when BitValid & BitReady.
- LastBit  output  1  qualifies final bit of current codeword.
- CodeLen  output  5  length of codeword being shifted, 1..16, held until next load.
- Error  output  1  one-cycle pulse: illegal token accepted and dropped.

## Operation
- Lookup: the exact inverse of the 0 <= nC < 2 decode table. Each legal (TotalCoeff, TrailingOnes) maps to a unique (Code[15:0], Len). Code is left-aligned in a 16-bit shift register, and the bits below Len are zero.
- Legal iff TotalCoeff <= 16 and TrailingOnes <= TotalCoeff. With TrailingOnes 2 bits wide, TrailingOnes <= 3 always holds.
- States:
  - IDLE: BitValid=0. On accept, go to SHIFT if legal. If illegal, pulse Error next cycle and stay in IDLE.
  - SHIFT: BitValid=1, Bit=ShReg[15], LastBit = (Remaining==1). On BitValid&BitReady, shift ShReg left 1 and decrement Remaining. When the last bit is consumed, go to IDLE, unless a new token is accepted in the same cycle, in which case reload and stay in SHIFT.
- Accept = InValid & InReady.
- InReady = ~Reset & (IDLE | (SHIFT & LastBit & BitReady)). This gives zero-bubble back-to-back codewords.
- Remaining: 5-bit counter loaded with Len on accept. It never wraps; it is reloaded or idles at 0.
- Inputs are sampled only on accept. Changes while InReady=0 are ignored.
- An illegal token accepted back-to-back ends the stream: the block goes to IDLE and pulses Error.

## Timing
- Reset values: BitValid=0, Bit=0, LastBit=0, CodeLen=0, Error=0, state IDLE, ShReg=0, Remaining=0. InReady=0 while Reset=1, and 1 in the first cycle after.
- Reset mid-codeword aborts it. Outputs take reset values at that edge, and no further bits from the aborted code appear.
- Latency: token accepted at edge N, so the first bit is valid after edge N (cycle N+1). Error is high for exactly cycle N+1 on an illegal accept.
- With BitReady held at 1, a Len-bit code occupies exactly Len cycles. Back-to-back tokens stream with no idle cycle.
- BitReady=0 stalls: Bit, LastBit and BitValid are held stable, and no token is accepted.
- CodeLen updates at the accept edge together with the first bit.

## Test plan
- Reset, then a sequence of tokens with BitReady=1: (0,0) -> bit 1, CodeLen=1, LastBit on bit 1. (1,1) -> 01, Len 2. (2,2) -> 001, Len 3. Total 6 bits over 6 consecutive cycles, no gaps.
- (1,0) -> 000101, Len 6. (16,3) -> 0000000000001000, Len 16. (13,1) -> 000000000000001, Len 15. Each checked bit-exact with LastBit only on the final bit.
- Illegal tokens (1,2), (17,0) and (31,3) -> Error high for exactly one cycle each, BitValid stays 0, InReady stays 1.
- Random BitReady stalls during (16,0) -> 0000000000000100. Bit and LastBit stay stable while stalled, and InReady=0 except in the LastBit & BitReady cycle.
- Reset asserted on the 5th bit of (15,2) -> outputs zero next cycle, then (0,0) emits a single 1.
- Exhaustive check: all 62 legal pairs driven through the encoder, output fed into the CoeffTokenROM02 decode path (16-bit left-aligned window). Decoded TotalCoeff/TrailingOnes/NumShift must equal the input and Len.
